// File: rtl/fpnew_operand_classify_snax.sv
// fpnew_operand_classify_snax
//   Input stage in front of the FPU opgroup slices. Each accepted request has
//   its operands NaN-box checked and classified for the source format. Unboxed
//   operands are replaced by the boxed canonical quiet NaN. Results sit in a
//   2-entry elastic buffer: 1-cycle latency, full throughput, and in_ready_o is
//   a flop.
//
//   Ports
//     clk_i, rst_ni        clock, synchronous active-low reset
//     flush_i              drop buffered entries and any same-cycle request
//     in_valid_i/ready_o   request handshake
//     operands_i           operand i at [i*WIDTH +: WIDTH]
//     src_fmt_i, tag_i     format of all operands, opaque tag
//     out_valid_o/ready_i  result handshake
//     operands_o, info_o   processed operands and fp_info_t (8 bits) per operand
//     fmt_o, tag_o         carried through
//     illegal_o            format is FP64 or undefined
//     busy_o               buffer not empty
//
//   fp_info_t bit order (MSB..LSB): normal, subnormal, zero, inf, nan,
//   signalling, quiet, boxed.
module fpnew_operand_classify_snax #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned TAG_WIDTH    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [NUM_OPERANDS*WIDTH-1:0]  operands_i,
  input  logic [2:0]                     src_fmt_i,
  input  logic [TAG_WIDTH-1:0]           tag_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_OPERANDS*WIDTH-1:0]  operands_o,
  output logic [NUM_OPERANDS*8-1:0]      info_o,
  output logic [2:0]                     fmt_o,
  output logic [TAG_WIDTH-1:0]           tag_o,
  output logic                           illegal_o,
  output logic                           busy_o
);

  localparam logic [2:0] FMT_FP32    = 3'd0;
  localparam logic [2:0] FMT_FP16    = 3'd2;
  localparam logic [2:0] FMT_FP8     = 3'd3;
  localparam logic [2:0] FMT_FP16ALT = 3'd4;

  typedef struct packed {
    logic [NUM_OPERANDS*WIDTH-1:0] ops;
    logic [NUM_OPERANDS*8-1:0]     info;
    logic [2:0]                    fmt;
    logic [TAG_WIDTH-1:0]          tag;
    logic                          illegal;
  } entry_t;

  // Returns {processed operand, fp_info_t}. Field extraction assumes WIDTH >= 32.
  function automatic logic [WIDTH+7:0] classify_op(input logic [WIDTH-1:0] op,
                                                   input logic [2:0]       fmt);
    logic [WIDTH-1:0] hi_ones;
    logic [WIDTH-1:0] canon;
    logic [WIDTH-1:0] op_out;
    logic [7:0]       info;
    logic             legal, boxed, exp_ones, exp_zero, man_zero, man_msb;
    hi_ones  = '0;
    canon    = '0;
    legal    = 1'b1;
    exp_ones = 1'b0;
    exp_zero = 1'b0;
    man_zero = 1'b0;
    man_msb  = 1'b0;
    unique case (fmt)
      FMT_FP32: begin
        hi_ones  = {WIDTH{1'b1}} << 32;
        canon    = WIDTH'(32'h7FC0_0000);
        exp_ones = &op[30:23];
        exp_zero = ~|op[30:23];
        man_zero = ~|op[22:0];
        man_msb  = op[22];
      end
      FMT_FP16: begin
        hi_ones  = {WIDTH{1'b1}} << 16;
        canon    = WIDTH'(32'h0000_7E00);
        exp_ones = &op[14:10];
        exp_zero = ~|op[14:10];
        man_zero = ~|op[9:0];
        man_msb  = op[9];
      end
      FMT_FP8: begin
        hi_ones  = {WIDTH{1'b1}} << 8;
        canon    = WIDTH'(32'h0000_007E);
        exp_ones = &op[6:2];
        exp_zero = ~|op[6:2];
        man_zero = ~|op[1:0];
        man_msb  = op[1];
      end
      FMT_FP16ALT: begin
        hi_ones  = {WIDTH{1'b1}} << 16;
        canon    = WIDTH'(32'h0000_7FC0);
        exp_ones = &op[14:7];
        exp_zero = ~|op[14:7];
        man_zero = ~|op[6:0];
        man_msb  = op[6];
      end
      default: legal = 1'b0;
    endcase
    // A format as wide as the operand has no box bits, so hi_ones is 0 and it is always boxed.
    boxed = ((op & hi_ones) == hi_ones);
    if (!legal) begin
      op_out = op;
      info   = 8'h00;
    end else if (!boxed) begin
      op_out = hi_ones | canon;
      info   = 8'b0000_1010;
    end else begin
      op_out = op;
      info   = {~exp_ones & ~exp_zero,
                exp_zero & ~man_zero,
                exp_zero & man_zero,
                exp_ones & man_zero,
                exp_ones & ~man_zero,
                exp_ones & ~man_zero & ~man_msb,
                exp_ones & ~man_zero & man_msb,
                1'b1};
    end
    return {op_out, info};
  endfunction

  entry_t in_entry;
  entry_t head_q, head_d, skid_q;
  logic [1:0] count_q, count_d;
  logic       in_ready_q;
  logic       load_head, load_skid;
  logic       push, pop;

  always_comb begin
    logic [WIDTH+7:0] res;
    in_entry         = '0;
    in_entry.fmt     = src_fmt_i;
    in_entry.tag     = tag_i;
    in_entry.illegal = (src_fmt_i == 3'd1) || (src_fmt_i > 3'd4);
    for (int i = 0; i < int'(NUM_OPERANDS); i++) begin
      res = classify_op(operands_i[i*WIDTH +: WIDTH], src_fmt_i);
      in_entry.ops[i*WIDTH +: WIDTH] = res[WIDTH+7:8];
      in_entry.info[i*8 +: 8]        = res[7:0];
    end
  end

  assign push = in_valid_i & in_ready_q;
  assign pop  = (count_q != 2'd0) & out_ready_i;

  // Head is what the consumer sees; skid catches one extra request while head stalls.
  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    load_head = 1'b0;
    load_skid = 1'b0;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: if (push) begin
          count_d = 2'd1; head_d = in_entry; load_head = 1'b1;
        end
        2'd1: begin
          if (push && pop) begin
            head_d = in_entry; load_head = 1'b1;
          end else if (push) begin
            count_d = 2'd2; load_skid = 1'b1;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: if (pop) begin
          count_d = 2'd1; head_d = skid_q; load_head = 1'b1;
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      if (load_head) head_q <= head_d;
      if (load_skid) skid_q <= in_entry;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign busy_o      = (count_q != 2'd0);
  assign operands_o  = head_q.ops;
  assign info_o      = head_q.info;
  assign fmt_o       = head_q.fmt;
  assign tag_o       = head_q.tag;
  assign illegal_o   = head_q.illegal;

endmodule
